control_plane: RTL and testbench

Loader and sequencer for the packet-processing datapath. After a one-cycle start pulse it accepts a fixed-order stream of phits on wr_data and fills three things in turn: a state table, per-column control/immediate config tables for the 6 PE columns (PEA0, PEA1, PEB, PEC0, PEC1, PED), and the external inbound register file through a write port. It then steps through the state-table entries, presenting the selected config words and an iteration count to the PE array, and raises done.

---
 rtl/control_plane.sv | 226 ++++++++++++++++++++++
 tb/tb_control_plane.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_plane.sv
// control_plane: loads a state table, per-column control/immediate tables and
// the inbound register file from a phit stream, then walks the state table to
// drive the PE array with config words and an iteration index.
module control_plane #(
  parameter int phit_size      = 512,
  parameter int num_col        = 6,
  parameter int dwidth_RFadd   = 8,
  parameter int entry_sz_state = 48,
  parameter int dwidth_double  = 64,
  parameter int cfg_depth      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [phit_size-1:0]             wr_data,
  input  logic                             start_loader,
  input  logic                             start_stream_in,
  input  logic [dwidth_RFadd-1:0]          num_entry_config_table,
  input  logic [dwidth_RFadd-1:0]          num_entry_inbound,
  output logic [24*num_col-1:0]            rd_data_ctrl,
  output logic [phit_size*(num_col-1)-1:0] rd_data_imm,
  output logic [entry_sz_state-1:0]        rd_data_state,
  output logic [dwidth_double-1:0]         itr,
  output logic                             ready,
  output logic                             done,
  output logic                             wr_en_RF,
  output logic [dwidth_RFadd-1:0]          wr_add_RF,
  output logic                             keep_start_stream_in
);

  localparam int CW = $clog2(cfg_depth);
  localparam logic [dwidth_RFadd-1:0] DEPTH_N = dwidth_RFadd'(cfg_depth);
  localparam logic [dwidth_RFadd-1:0] ONE_N   = dwidth_RFadd'(1);
  localparam logic [2:0] LAST_COL = 3'(num_col - 1);
  localparam logic [2:0] PEB_COL  = 3'd2;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD_STATE = 3'd1;
  localparam logic [2:0] S_LOAD_CTRL  = 3'd2;
  localparam logic [2:0] S_LOAD_IMM   = 3'd3;
  localparam logic [2:0] S_LOAD_INB   = 3'd4;
  localparam logic [2:0] S_WAIT       = 3'd5;
  localparam logic [2:0] S_RUN        = 3'd6;
  localparam logic [2:0] S_DONE       = 3'd7;

  logic [2:0]               fsm_q, fsm_d;
  logic [dwidth_RFadd-1:0]  cnt_q, cnt_d;
  logic [dwidth_RFadd-1:0]  n_q, n_d;
  logic [dwidth_RFadd-1:0]  ninb_q, ninb_d;
  logic [2:0]               col_q, col_d;
  logic [CW-1:0]            sp_q, sp_d;
  logic [dwidth_double-1:0] itr_q, itr_d;
  logic                     keep_q, keep_d;

  logic [entry_sz_state-1:0] st_q   [cfg_depth];
  logic [23:0]               ctrl_q [num_col][cfg_depth];
  logic [phit_size-1:0]      imm_q  [num_col-1][cfg_depth];

  logic [entry_sz_state-1:0] ent;
  logic [dwidth_double-1:0]  lim_m1;
  logic                      ent_last;
  logic                      cnt_last;
  logic                      run;
  logic [CW-1:0]             wr_idx;

  // Entry count of 0 still loads one entry; anything beyond the table depth is clamped.
  function automatic logic [dwidth_RFadd-1:0] clamp_n(input logic [dwidth_RFadd-1:0] n);
    if (n == '0)          return ONE_N;
    else if (n > DEPTH_N) return DEPTH_N;
    else                  return n;
  endfunction

  // PEB (column 2) owns no immediate slot, so later columns shift down by one.
  function automatic logic [2:0] imm_slot(input logic [2:0] col);
    return (col < PEB_COL) ? col : col - 3'd1;
  endfunction

  assign ent      = st_q[sp_q];
  assign lim_m1   = (ent[31:0] == 32'd0) ? '0 : dwidth_double'(ent[31:0] - 32'd1);
  assign ent_last = ent[33] | ~ent[47] | (dwidth_RFadd'(sp_q) == n_q - ONE_N);
  assign cnt_last = (cnt_q == n_q - ONE_N);
  assign run      = (fsm_q == S_RUN);
  assign wr_idx   = cnt_q[CW-1:0];

  // Next-state logic for the sequencer, load counters and run pointer.
  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    n_d    = n_q;
    ninb_d = ninb_q;
    col_d  = col_q;
    sp_d   = sp_q;
    itr_d  = itr_q;
    keep_d = keep_q | start_stream_in;
    case (fsm_q)
      S_IDLE, S_DONE: begin
        if (start_loader) begin
          fsm_d  = S_LOAD_STATE;
          cnt_d  = '0;
          col_d  = '0;
          n_d    = clamp_n(num_entry_config_table);
          ninb_d = num_entry_inbound;
        end
      end
      S_LOAD_STATE: begin
        if (cnt_last) begin
          fsm_d = S_LOAD_CTRL;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + ONE_N;
        end
      end
      S_LOAD_CTRL: begin
        if (cnt_last) begin
          fsm_d = S_LOAD_IMM;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + ONE_N;
        end
      end
      S_LOAD_IMM: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (col_q == LAST_COL) begin
            fsm_d = (ninb_q == '0) ? S_WAIT : S_LOAD_INB;
          end else begin
            col_d = col_q + 3'd1;
            fsm_d = S_LOAD_CTRL;
          end
        end else begin
          cnt_d = cnt_q + ONE_N;
        end
      end
      S_LOAD_INB: begin
        if (cnt_q == ninb_q - ONE_N) begin
          fsm_d = S_WAIT;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + ONE_N;
        end
      end
      S_WAIT: begin
        if (keep_q) begin
          fsm_d = S_RUN;
          sp_d  = '0;
          itr_d = '0;
        end
      end
      S_RUN: begin
        if (itr_q == lim_m1) begin
          if (ent_last) begin
            fsm_d  = S_DONE;
            keep_d = 1'b0;
          end else begin
            sp_d  = sp_q + 1'b1;
            itr_d = '0;
          end
        end else begin
          itr_d = itr_q + 1'b1;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= S_IDLE;
      cnt_q  <= '0;
      n_q    <= '0;
      ninb_q <= '0;
      col_q  <= '0;
      sp_q   <= '0;
      itr_q  <= '0;
      keep_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      n_q    <= n_d;
      ninb_q <= ninb_d;
      col_q  <= col_d;
      sp_q   <= sp_d;
      itr_q  <= itr_d;
      keep_q <= keep_d;
    end
  end

  // Table capture from the loader stream; PEB immediates are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < cfg_depth; k++) begin
        st_q[k] <= '0;
        for (int c = 0; c < num_col; c++)     ctrl_q[c][k] <= '0;
        for (int s = 0; s < num_col - 1; s++) imm_q[s][k]  <= '0;
      end
    end else begin
      case (fsm_q)
        S_LOAD_STATE: st_q[wr_idx] <= wr_data[phit_size-1 -: entry_sz_state];
        S_LOAD_CTRL:  ctrl_q[col_q][wr_idx] <= wr_data[phit_size-1 -: 24];
        S_LOAD_IMM:   if (col_q != PEB_COL) imm_q[imm_slot(col_q)][wr_idx] <= wr_data;
        default: ;
      endcase
    end
  end

  // Output presentation: config words only while running, RF port only while loading inbound.
  always_comb begin
    rd_data_ctrl  = '0;
    rd_data_imm   = '0;
    rd_data_state = '0;
    itr           = '0;
    if (run) begin
      rd_data_state = ent;
      itr           = itr_q;
      for (int c = 0; c < num_col; c++)     rd_data_ctrl[24*c +: 24]              = ctrl_q[c][sp_q];
      for (int s = 0; s < num_col - 1; s++) rd_data_imm[phit_size*s +: phit_size] = imm_q[s][sp_q];
    end
  end

  assign ready                = run;
  assign done                 = (fsm_q == S_DONE);
  assign wr_en_RF             = (fsm_q == S_LOAD_INB);
  assign wr_add_RF            = wr_en_RF ? cnt_q : '0;
  assign keep_start_stream_in = keep_q;

endmodule

// File: tb/tb_control_plane.sv
// Bench for control_plane: directed and randomized load/run sequences checked
// against an iteration trace computed from the table contents.
module tb_control_plane;

  logic          clk = 1'b0;
  logic          rst;
  logic [511:0]  wr_data;
  logic          start_loader;
  logic          start_stream_in;
  logic [7:0]    num_entry_config_table;
  logic [7:0]    num_entry_inbound;
  logic [143:0]  rd_data_ctrl;
  logic [2559:0] rd_data_imm;
  logic [47:0]   rd_data_state;
  logic [63:0]   itr;
  logic          ready;
  logic          done;
  logic          wr_en_RF;
  logic [7:0]    wr_add_RF;
  logic          keep_start_stream_in;

  int checks = 0;
  int errors = 0;

  logic [47:0]  m_st   [4];
  logic [23:0]  m_ctrl [6][4];
  logic [511:0] m_imm  [6][4];
  int           slot_col [5] = '{0, 1, 3, 4, 5};

  control_plane dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .start_loader(start_loader),
    .start_stream_in(start_stream_in), .num_entry_config_table(num_entry_config_table),
    .num_entry_inbound(num_entry_inbound), .rd_data_ctrl(rd_data_ctrl),
    .rd_data_imm(rd_data_imm), .rd_data_state(rd_data_state), .itr(itr),
    .ready(ready), .done(done), .wr_en_RF(wr_en_RF), .wr_add_RF(wr_add_RF),
    .keep_start_stream_in(keep_start_stream_in)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [511:0] obs, input logic [511:0] avoid);
    checks++;
    assert (obs !== avoid) else begin
      errors++;
      $error("FAIL %s observed=%0h expected_not=%0h", tag, obs, avoid);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic int eff_n(input int n);
    if (n == 0) return 1;
    if (n > 4)  return 4;
    return n;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 4; k++) begin
      logic [47:0] e;
      e = {$urandom, $urandom};
      e[47]   = ($urandom_range(0, 5) != 0);
      e[33]   = ($urandom_range(0, 3) == 0);
      e[31:0] = $urandom_range(0, 5);
      m_st[k] = e;
      for (int c = 0; c < 6; c++) begin
        m_ctrl[c][k] = 24'($urandom);
        m_imm[c][k]  = rnd512();
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 512'(ready), 512'(0));
    chk({tag, "_wr_en"}, 512'(wr_en_RF), 512'(0));
    chk({tag, "_wr_add"}, 512'(wr_add_RF), 512'(0));
    chk({tag, "_itr"}, 512'(itr), 512'(0));
    chk({tag, "_state"}, 512'(rd_data_state), 512'(0));
    chk({tag, "_ctrl"}, 512'(rd_data_ctrl), 512'(0));
    chk({tag, "_imm2"}, rd_data_imm[1024 +: 512], 512'(0));
    chk({tag, "_keep"}, 512'(keep_start_stream_in), 512'(0));
  endtask

  // Drives the whole load stream for the current model tables.
  task automatic drive_load(input int nraw, input int ninb, input bit ssi);
    int ne;
    logic [511:0] w;
    ne = eff_n(nraw);
    start_stream_in        = ssi;
    num_entry_config_table = 8'(nraw);
    num_entry_inbound      = 8'(ninb);
    start_loader           = 1'b1;
    step();
    start_loader = 1'b0;
    for (int k = 0; k < ne; k++) begin
      w = rnd512();
      w[511:464] = m_st[k];
      wr_data = w;
      chk("load_ready", 512'(ready), 512'(0));
      step();
    end
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < ne; k++) begin
        w = rnd512();
        w[511:488] = m_ctrl[c][k];
        wr_data = w;
        chk("load_wr_en_off", 512'(wr_en_RF), 512'(0));
        step();
      end
      for (int k = 0; k < ne; k++) begin
        wr_data = m_imm[c][k];
        step();
      end
    end
    for (int i = 0; i < ninb; i++) begin
      wr_data = 512'd1;
      chk("inb_wr_en", 512'(wr_en_RF), 512'(1));
      chk("inb_wr_add", 512'(wr_add_RF), 512'(i));
      chk("inb_ready", 512'(ready), 512'(0));
      step();
    end
    chk("post_load_wr_en", 512'(wr_en_RF), 512'(0));
  endtask

  // Builds the expected (entry, iteration) trace and checks every RUN cycle against it.
  task automatic run_check(input int nraw, input bit imm_distinct, input int exp_lat);
    int tsp[$];
    int titr[$];
    int ne, lim, w;
    ne = eff_n(nraw);
    for (int sp = 0; sp < ne; sp++) begin
      lim = (m_st[sp][31:0] == 0) ? 1 : int'(m_st[sp][31:0]);
      for (int i = 0; i < lim; i++) begin
        tsp.push_back(sp);
        titr.push_back(i);
      end
      if (!m_st[sp][47] || m_st[sp][33]) break;
    end
    w = 0;
    while (ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    chk("run_start", 512'(ready), 512'(1));
    if (exp_lat >= 0) chk("run_latency", 512'(w), 512'(exp_lat));
    start_stream_in = 1'b0;
    for (int j = 0; j < tsp.size(); j++) begin
      chk("run_ready", 512'(ready), 512'(1));
      chk("run_done", 512'(done), 512'(0));
      chk("run_itr", 512'(itr), 512'(titr[j]));
      chk("run_state", 512'(rd_data_state), 512'(m_st[tsp[j]]));
      for (int c = 0; c < 6; c++)
        chk("run_ctrl", 512'(rd_data_ctrl[24*c +: 24]), 512'(m_ctrl[c][tsp[j]]));
      for (int s = 0; s < 5; s++) begin
        chk("run_imm", rd_data_imm[512*s +: 512], m_imm[slot_col[s]][tsp[j]]);
        if (imm_distinct) chk_ne("peb_imm_hidden", rd_data_imm[512*s +: 512], m_imm[2][tsp[j]]);
      end
      step();
    end
    chk("end_done", 512'(done), 512'(1));
    chk("end_ready", 512'(ready), 512'(0));
    chk("end_keep", 512'(keep_start_stream_in), 512'(0));
    chk("end_state", 512'(rd_data_state), 512'(0));
    chk("end_ctrl", 512'(rd_data_ctrl), 512'(0));
  endtask

  int nlist [5] = '{0, 4, 6, 1, 3};
  int ilist [5] = '{0, 3, 1, 0, 2};

  initial begin
    rst = 1'b1;
    wr_data = '0;
    start_loader = 1'b0;
    start_stream_in = 1'b0;
    num_entry_config_table = '0;
    num_entry_inbound = '0;

    // Reset and quiet idle.
    step();
    rst = 1'b0;
    check_idle_outputs("reset");
    chk("reset_done", 512'(done), 512'(0));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_wr_en", 512'(wr_en_RF), 512'(0));
    end

    // FIR load and run.
    for (int k = 0; k < 4; k++) begin
      m_st[k] = '0;
      for (int c = 0; c < 6; c++) begin
        m_ctrl[c][k] = '0;
        m_imm[c][k]  = '0;
      end
    end
    m_st[0] = 48'h8000_00000010;
    m_st[1] = 48'h8002_00000000;
    m_ctrl[0][1] = 24'h880000;
    m_ctrl[2][1] = 24'h800000;
    m_ctrl[3][1] = 24'h908004;
    m_ctrl[4][1] = 24'hA00000;
    m_ctrl[5][1] = 24'h900000;
    drive_load(2, 16, 1'b1);
    run_check(2, 1'b0, 1);
    step();
    step();
    chk("done_held", 512'(done), 512'(1));

    // Backpressure: park in WAIT until a single start_stream_in pulse.
    fill_random();
    drive_load(3, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("wait_ready", 512'(ready), 512'(0));
      chk("wait_done", 512'(done), 512'(0));
      step();
    end
    start_stream_in = 1'b1;
    step();
    start_stream_in = 1'b0;
    chk("pulse_keep", 512'(keep_start_stream_in), 512'(1));
    run_check(3, 1'b1, 1);

    // Randomized tables across entry-count boundaries.
    for (int t = 0; t < 5; t++) begin
      fill_random();
      drive_load(nlist[t], ilist[t], 1'b1);
      run_check(nlist[t], 1'b1, 1);
    end

    // Reset while loading immediates, then a clean reload.
    fill_random();
    num_entry_config_table = 8'd2;
    num_entry_inbound = 8'd1;
    start_loader = 1'b1;
    step();
    start_loader = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_data = rnd512();
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("midload_rst");
    chk("midload_done", 512'(done), 512'(0));
    step();
    chk("midload_idle_wr_en", 512'(wr_en_RF), 512'(0));
    drive_load(2, 1, 1'b1);
    run_check(2, 1'b1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
